// File: rtl/disp_scan_ctrl.sv
// Display scan scheduler: steps six digit slots, blanks at each change, double-buffers the BCD result.
// Optional PWM dimming is enabled by defining DISP_DIM_EN (adds dim_level_i).
module disp_scan_ctrl #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        latch_i,
   input  logic [3:0]  q5_i,
   input  logic [3:0]  q4_i,
   input  logic [3:0]  q3_i,
   input  logic [3:0]  q2_i,
   input  logic [3:0]  q1_i,
   input  logic [3:0]  q0_i,
`ifdef DISP_DIM_EN
   input  logic [3:0]  dim_level_i,
`endif
   output logic [2:0]  disp_select_o,
   output logic [3:0]  digit_data_o,
   output logic [23:0] hold_bus_o,
   output logic [5:0]  digit_en_n_o,
   output logic        frame_start_o,
   output logic        state_o,
   output logic        pending_o
);

   localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYC);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  sel_q, sel_d;
   logic        started_q;
   logic [23:0] disp_q, disp_d;
   logic [23:0] shadow_q, shadow_d;
   logic        pending_q, pending_d;
   logic [3:0]  digit_q, digit_d;
   logic [5:0]  en_n_q, en_n_d;
   logic        fs_q, fs_d;
   logic        wrap;
   logic        lit;
   logic [23:0] q_bus;
`ifdef DISP_DIM_EN
   logic [3:0]  pwm_q, pwm_d;
   logic [3:0]  dim_q, dim_d;
`endif

   assign q_bus = {q5_i, q4_i, q3_i, q2_i, q1_i, q0_i};

   always_comb begin
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      disp_d    = disp_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      lit       = 1'b1;
      // The first edge after reset release enters slot 0 without advancing the counter.
      if (!started_q) begin
         cnt_d = '0;
         sel_d = 3'd0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
         sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      wrap = started_q && (cnt_q == LAST_CNT) && (sel_q == 3'd5);

      if (wrap) begin
         if (latch_i) begin
            disp_d   = q_bus;
            shadow_d = q_bus;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (latch_i) begin
         shadow_d  = q_bus;
         pending_d = 1'b1;
      end

      state_d = (cnt_d < BLANK_CNT) ? ST_BLANK : ST_SHOW;

`ifdef DISP_DIM_EN
      pwm_d = pwm_q;
      dim_d = dim_q;
      if (state_d == ST_SHOW) begin
         if (state_q == ST_BLANK) begin
            pwm_d = 4'd0;
            dim_d = dim_level_i;
         end else begin
            pwm_d = pwm_q + 4'd1;
         end
         lit = (pwm_d < dim_d);
      end
`endif

      en_n_d = 6'b111111;
      if (state_d == ST_SHOW && lit) begin
         en_n_d = ~(6'b000001 << sel_d);
      end

      case (sel_d)
         3'd0:    digit_d = disp_d[23:20];
         3'd1:    digit_d = disp_d[19:16];
         3'd2:    digit_d = disp_d[15:12];
         3'd3:    digit_d = disp_d[11:8];
         3'd4:    digit_d = disp_d[7:4];
         3'd5:    digit_d = disp_d[3:0];
         default: digit_d = 4'hF;
      endcase

      fs_d = !started_q || wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_BLANK;
         cnt_q     <= '0;
         sel_q     <= 3'd0;
         started_q <= 1'b0;
         disp_q    <= 24'hFFFFFF;
         shadow_q  <= 24'hFFFFFF;
         pending_q <= 1'b0;
         digit_q   <= 4'hF;
         en_n_q    <= 6'b111111;
         fs_q      <= 1'b0;
`ifdef DISP_DIM_EN
         pwm_q     <= 4'd0;
         dim_q     <= 4'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         started_q <= 1'b1;
         disp_q    <= disp_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         digit_q   <= digit_d;
         en_n_q    <= en_n_d;
         fs_q      <= fs_d;
`ifdef DISP_DIM_EN
         pwm_q     <= pwm_d;
         dim_q     <= dim_d;
`endif
      end
   end

   assign disp_select_o = sel_q;
   assign digit_data_o  = digit_q;
   assign hold_bus_o    = disp_q;
   assign digit_en_n_o  = en_n_q;
   assign frame_start_o = fs_q;
   assign state_o       = state_q;
   assign pending_o     = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: cycle-time model of the scan schedule and double buffer, random latches.
module tb_disp_scan_ctrl;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 6 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic latch = 1'b0;
  logic [3:0] q[6];
  logic [2:0] disp_select;
  logic [3:0] digit_data;
  logic [23:0] hold_bus;
  logic [5:0] digit_en_n;
  logic frame_start, state_o, pending_o;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .latch_i(latch),
    .q5_i(q[0]), .q4_i(q[1]), .q3_i(q[2]), .q2_i(q[3]), .q1_i(q[4]), .q0_i(q[5]),
`ifdef DISP_DIM_EN
    .dim_level_i(4'hF),
`endif
    .disp_select_o(disp_select), .digit_data_o(digit_data), .hold_bus_o(hold_bus),
    .digit_en_n_o(digit_en_n), .frame_start_o(frame_start), .state_o(state_o),
    .pending_o(pending_o)
  );

  // model: t counts cycles since the first edge after reset release
  int t;
  logic [3:0] m_disp[6];
  logic [3:0] m_shadow[6];
  bit m_pend;
  int n_vec = 0, n_err = 0;
  int fs_cnt, fs_first, fs_last, en_low_cnt;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = -1;
    for (int i = 0; i < 6; i++) begin
      m_disp[i] = 4'hF;
      m_shadow[i] = 4'hF;
    end
    m_pend = 0;
  endtask

  task automatic model_edge();
    t++;
    if (t > 0 && t % FRAME == 0) begin
      for (int i = 0; i < 6; i++) if (latch) m_disp[i] = q[i]; else if (m_pend) m_disp[i] = m_shadow[i];
      if (latch) for (int i = 0; i < 6; i++) m_shadow[i] = q[i];
      m_pend = 0;
    end else if (latch) begin
      for (int i = 0; i < 6; i++) m_shadow[i] = q[i];
      m_pend = 1;
    end
  endtask

  task automatic compare_all();
    int slot, pos;
    logic [5:0] exp_en;
    logic [23:0] exp_hold;
    slot = (t / SD) % 6;
    pos = t % SD;
    exp_en = (pos < BC) ? 6'h3F : ~(6'b1 << slot);
    exp_hold = {m_disp[0], m_disp[1], m_disp[2], m_disp[3], m_disp[4], m_disp[5]};
    check("disp_select", 24'(disp_select), 24'(slot));
    check("digit_en_n", 24'(digit_en_n), 24'(exp_en));
    check("digit_data", 24'(digit_data), 24'(m_disp[slot]));
    check("hold_bus", hold_bus, exp_hold);
    check("frame_start", 24'(frame_start), 24'(t % FRAME == 0));
    check("state", 24'(state_o), 24'(pos >= BC));
    check("pending", 24'(pending_o), 24'(m_pend));
    if (frame_start) begin
      if (fs_cnt == 0) fs_first = t;
      fs_last = t;
      fs_cnt++;
    end
    if (digit_en_n != 6'h3F) en_low_cnt++;
  endtask

  // drive inputs now (at a negedge), apply one edge, compare, return at the next negedge
  task automatic cycle(input bit l, input logic [23:0] qbus);
    latch = l;
    if (l) for (int i = 0; i < 6; i++) q[i] = qbus[(5 - i) * 4 +: 4];
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[i * 4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic run_until_next_slot(input int slot);
    int guard = 0;
    while (((t + 1) / SD) % 6 != slot || (t + 1) % SD != 0) begin
      cycle(0, 24'h0);
      guard++;
      if (guard > 200) begin
        check("wait_slot_timeout", 24'(guard), 24'd0);
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) q[i] = 4'd0;
    model_reset();
    fs_cnt = 0; fs_first = -1; fs_last = -1; en_low_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_select", 24'(disp_select), 24'd0);
    check("rst_en_n", 24'(digit_en_n), 24'h3F);
    check("rst_digit", 24'(digit_data), 24'hF);
    check("rst_hold", hold_bus, 24'hFFFFFF);
    check("rst_fs", 24'(frame_start), 24'd0);
    rst_n = 1'b1;

    // free run: 96 cycles
    for (int i = 0; i < 96; i++) begin
      cycle(0, 24'h0);
      if (t == 0) check("fs_cycle0", 24'(frame_start), 24'd1);
      if (t == 2) check("en_after_2", 24'(digit_en_n), 24'h3E);
    end
    check("fs_count", 24'(fs_cnt), 24'd2);
    check("fs_gap", 24'(fs_last - fs_first), 24'd48);
    check("en_low_count", 24'(en_low_cnt), 24'd72);

    // latch 1..6 while slot 2 is displayed
    run_until_next_slot(2);
    cycle(0, 24'h0);
    cycle(1, 24'h123456);
    check("pend_after_latch", 24'(pending_o), 24'd1);
    run_until_next_slot(0);
    cycle(0, 24'h0);
    check("hold_123456", hold_bus, 24'h123456);
    check("slot0_is_1", 24'(digit_data), 24'h1);
    repeat (SD) cycle(0, 24'h0);
    check("slot1_is_2", 24'(digit_data), 24'h2);

    // latch exactly on the wrap edge
    run_until_next_slot(0);
    cycle(1, 24'h987654);
    check("wrap_slot0_9", 24'(digit_data), 24'h9);
    check("wrap_pend0", 24'(pending_o), 24'd0);
    check("wrap_hold", hold_bus, 24'h987654);

    // two latches in one frame: last one wins
    repeat (5) cycle(0, 24'h0);
    cycle(1, 24'h305172);
    repeat (7) cycle(0, 24'h0);
    cycle(1, 24'h864209);
    run_until_next_slot(0);
    cycle(0, 24'h0);
    check("last_latch_wins", hold_bus, 24'h864209);

    // random latch traffic
    for (int i = 0; i < 600; i++) cycle($urandom_range(0, 15) == 0, rand_bcd());

    // reset mid-SHOW of slot 3
    run_until_next_slot(3);
    repeat (4) cycle(0, 24'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_en_n", 24'(digit_en_n), 24'h3F);
    check("async_digit", 24'(digit_data), 24'hF);
    check("async_select", 24'(disp_select), 24'd0);
    check("async_hold", hold_bus, 24'hFFFFFF);
    check("async_pend", 24'(pending_o), 24'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) cycle($urandom_range(0, 11) == 0, rand_bcd());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=running expected=done", t);
    $fatal(1, "watchdog");
  end
endmodule
